// File: rtl/control_unit.sv
// Multicycle MIPS control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes and ALU op, halts on unsupported encodings and counts retirements.
module control_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       op_control,
  input  logic [5:0]       funct_control,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             store,
  output logic             w_reg,
  output logic             w_data,
  output logic [5:0]       op_alu,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // The branch decision lives in the datapath; zero is exposed here but not consumed.
  logic unused_zero;
  assign unused_zero = zero;

  logic is_r_sub;
  logic r_funct_ok;

  assign is_r_sub   = (op_control == OP_R) && (funct_control == FN_SUB);
  assign r_funct_ok = (funct_control == FN_ADD) || (funct_control == FN_SUB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (store) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    w_reg   = 1'b0;
    w_data  = 1'b0;
    op_alu  = ALU_ADD;

    unique case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        unique case (op_control)
          OP_R:                        state_d = r_funct_ok ? S_EXEC : S_HALT;
          OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          OP_J: begin
            state_d = S_FETCH;
            store   = 1'b1;
          end
          default:                     state_d = S_HALT;
        endcase
      end

      S_EXEC: begin
        if (op_control == OP_BEQ || is_r_sub) op_alu = ALU_SUB;
        unique case (op_control)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          OP_BEQ: begin
            state_d = S_FETCH;
            store   = 1'b1;
          end
          default:       state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        if (mem_ready) begin
          if (op_control == OP_SW) begin
            state_d = S_FETCH;
            w_data  = 1'b1;
            store   = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        // Keep SUB through write-back so the register file captures the subtract result.
        if (is_r_sub) op_alu = ALU_SUB;
        state_d = S_FETCH;
        w_reg   = 1'b1;
        store   = 1'b1;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase

    // Disable freezes the sequence in place and suppresses every strobe.
    if (!en) begin
      state_d = state_q;
      store   = 1'b0;
      w_reg   = 1'b0;
      w_data  = 1'b0;
    end
  end

  assign halt        = (state_q == S_HALT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit: an instruction-level latency model predicts
// strobes, ALU op, halt and retire count each cycle, plus directed literal scenarios.
module tb_control_unit;

  localparam int unsigned CW = 4;
  localparam logic [5:0] ADD_OP = 6'b100000;
  localparam logic [5:0] SUB_OP = 6'b100010;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [5:0]    op_control = '0;
  logic [5:0]    funct_control = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          store, w_reg, w_data, halt;
  logic [5:0]    op_alu;
  logic [CW-1:0] instr_count;

  control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .op_control(op_control), .funct_control(funct_control),
    .zero(zero), .mem_ready(mem_ready), .store(store), .w_reg(w_reg), .w_data(w_data),
    .op_alu(op_alu), .halt(halt), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: position within the instruction plus its total length.
  int            p;
  int            len;
  bit            m_mem, m_wreg, m_wdata, m_beq, m_rsub, m_bad, m_halted, need_new;
  logic [CW-1:0] m_cnt;
  logic [11:0]   fq[$];
  bit            en_v = 1'b1;
  bit            rand_ready = 1'b0;
  int            mr_hold = 0;
  int            n_store, n_wreg, n_wdata;

  task automatic model_reset();
    p = 0; m_halted = 0; m_cnt = '0; need_new = 1; m_bad = 0;
  endtask

  task automatic decode_model(input logic [5:0] op, input logic [5:0] fn);
    m_mem = 0; m_wreg = 0; m_wdata = 0; m_beq = 0; m_rsub = 0; m_bad = 0; len = 99;
    case (op)
      6'b000000: begin
        if (fn == 6'b100000) begin len = 4; m_wreg = 1; end
        else if (fn == 6'b100010) begin len = 4; m_wreg = 1; m_rsub = 1; end
        else m_bad = 1;
      end
      6'b001000: begin len = 4; m_wreg = 1; end
      6'b100011: begin len = 5; m_wreg = 1; m_mem = 1; end
      6'b101011: begin len = 4; m_wdata = 1; m_mem = 1; end
      6'b000100: begin len = 3; m_beq = 1; end
      6'b000010: len = 2;
      default:   m_bad = 1;
    endcase
  endtask

  task automatic pick_instr();
    logic [5:0] op, fn;
    int r;
    if (fq.size() > 0) begin
      {op, fn} = fq.pop_front();
    end else begin
      r  = $urandom_range(0, 19);
      fn = 6'($urandom);
      case (r)
        0, 1, 2, 3:   begin op = 6'b000000; fn = 6'b100000; end
        4, 5, 6:      begin op = 6'b000000; fn = 6'b100010; end
        7, 8, 9:      op = 6'b001000;
        10, 11, 12:   op = 6'b100011;
        13, 14, 15:   op = 6'b101011;
        16, 17:       op = 6'b000100;
        18:           op = 6'b000010;
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            op = 6'b000000;
            while (fn == 6'b100000 || fn == 6'b100010) fn = 6'($urandom);
          end else begin
            op = 6'($urandom);
            while (op == 6'b000000 || op == 6'b001000 || op == 6'b100011 ||
                   op == 6'b101011 || op == 6'b000100 || op == 6'b000010) op = 6'($urandom);
          end
        end
      endcase
    end
    op_control = op;
    funct_control = fn;
    decode_model(op, fn);
  endtask

  // One cycle: drive inputs at negedge, compare at negedge+1, then advance the model.
  task automatic step();
    bit fin, stall, act, e_store;
    logic [5:0] e_op;
    @(negedge clk);
    if (need_new && !m_halted) begin
      pick_instr();
      need_new = 0;
    end
    en = en_v;
    zero = 1'($urandom);
    if (rand_ready) mem_ready = 1'($urandom);
    else if (m_mem && p == 3 && mr_hold > 0) begin
      mem_ready = 1'b0;
      if (en_v) mr_hold--;
    end else mem_ready = 1'b1;
    #1;
    fin   = (p == len - 1);
    stall = m_mem && (p == 3) && !mem_ready;
    act   = en && !stall && !m_bad && !m_halted;
    e_store = act && fin;
    e_op = (!m_halted && ((m_beq && p == 2) || (m_rsub && p >= 2))) ? SUB_OP : ADD_OP;
    chk("store", int'(store), int'(e_store));
    chk("w_reg", int'(w_reg), int'(e_store && m_wreg));
    chk("w_data", int'(w_data), int'(e_store && m_wdata));
    chk("op_alu", int'(op_alu), int'(e_op));
    chk("halt", int'(halt), int'(m_halted));
    chk("instr_count", int'(instr_count), int'(m_cnt));
    n_store += int'(store); n_wreg += int'(w_reg); n_wdata += int'(w_data);
    if (en && !m_halted) begin
      if (m_bad) begin
        if (p == 1) m_halted = 1; else p++;
      end else if (!stall) begin
        if (fin) begin
          m_cnt = m_cnt + 1'b1;
          p = 0;
          need_new = 1;
        end else p++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_store", int'(store), 0);
    chk("rst_wreg", int'(w_reg), 0);
    chk("rst_wdata", int'(w_data), 0);
    chk("rst_op_alu", int'(op_alu), int'(ADD_OP));
    chk("rst_halt", int'(halt), 0);
    chk("rst_count", int'(instr_count), 0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic run_until_done(inout int cyc);
    int guard = 0;
    while (!need_new && !m_halted && guard < 60) begin
      step();
      cyc++;
      guard++;
    end
    if (guard >= 60) chk("timeout", 1, 0);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int hold,
                           output int cyc);
    fq.push_back({op, fn});
    mr_hold = hold;
    cyc = 0;
    step();
    cyc = 1;
    run_until_done(cyc);
  endtask

  task automatic clr_counts();
    n_store = 0; n_wreg = 0; n_wdata = 0;
  endtask

  initial begin
    int cyc;
    int halted_for;
    model_reset();
    clr_counts();
    do_reset();

    clr_counts();
    run_instr(6'b000000, 6'b100000, 0, cyc);
    chk("add_cycles", cyc, 4);
    chk("add_wreg_pulses", n_wreg, 1);
    @(posedge clk); #1;
    chk("add_count", int'(instr_count), 1);

    clr_counts();
    run_instr(6'b100011, 6'b000000, 3, cyc);
    chk("lw_wait3_cycles", cyc, 8);
    chk("lw_wdata_pulses", n_wdata, 0);
    chk("lw_store_pulses", n_store, 1);

    run_instr(6'b101011, 6'b000000, 0, cyc);
    chk("sw_cycles", cyc, 4);
    clr_counts();
    run_instr(6'b101011, 6'b000000, 2, cyc);
    chk("sw_wait2_cycles", cyc, 6);
    chk("sw_wdata_pulses", n_wdata, 1);

    run_instr(6'b000100, 6'b000000, 0, cyc);
    chk("beq1_cycles", cyc, 3);
    run_instr(6'b000100, 6'b000000, 0, cyc);
    chk("beq0_cycles", cyc, 3);
    run_instr(6'b000010, 6'b000000, 0, cyc);
    chk("j_cycles", cyc, 2);
    @(posedge clk); #1;
    chk("count_after_seq", int'(instr_count), 7);

    foreach (fq[i]) fq.delete(i);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) run_instr(6'b111111, 6'b000000, 0, cyc);
      else        run_instr(6'b000000, 6'b100100, 0, cyc);
      chk("halt_entry_cycles", cyc, 2);
      clr_counts();
      for (int i = 0; i < 20; i++) step();
      chk("halt_strobes", n_store + n_wreg + n_wdata, 0);
      chk("halt_flag", int'(halt), 1);
      do_reset();
    end

    // Disable for five cycles while ADDI sits in EXEC.
    clr_counts();
    fq.push_back({6'b001000, 6'b000000});
    step(); step();
    en_v = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en_v = 1'b1;
    cyc = 7;
    run_until_done(cyc);
    chk("addi_en_cycles", cyc, 9);
    chk("addi_wreg_pulses", n_wreg, 1);

    // Reset while LW waits in MEM.
    clr_counts();
    fq.push_back({6'b100011, 6'b000000});
    mr_hold = 5;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    chk("lw_abort_writes", n_wreg + n_wdata, 0);
    mr_hold = 0;

    for (int i = 0; i < 16; i++) begin
      run_instr(6'b000010, 6'b000000, 0, cyc);
      if (i == 14) begin
        @(posedge clk); #1;
        chk("count_15", int'(instr_count), 15);
      end
    end
    @(posedge clk); #1;
    chk("count_wrap", int'(instr_count), 0);

    rand_ready = 1'b1;
    halted_for = 0;
    for (int i = 0; i < 3000; i++) begin
      en_v = ($urandom_range(0, 7) != 0);
      step();
      if (m_halted) halted_for++;
      if (halted_for > 8 || $urandom_range(0, 399) == 0) begin
        do_reset();
        halted_for = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
